// File: rtl/sky130_ef_ip__xtal_osc_ctrl_if.sv
// Signal bundle between the crystal oscillator controller and its
// environment: enable/standby requests, startup and frequency-window
// configuration, the raw oscillator output, and the controller's registered
// status and pin-drive outputs.
//
// Handshake semantics: there is no valid/ready transfer on this bundle.
// en and stdby_req are level requests sampled on every rising clk edge;
// the configuration words are quasi-static; every output is a registered
// level that changes only on a clk edge or on reset.
interface sky130_ef_ip__xtal_osc_ctrl_if;
    logic        en;
    logic        stdby_req;
    logic [15:0] startup_cycles;
    logic [7:0]  min_edges;
    logic [7:0]  max_edges;
    logic        xtal_dout;
    logic        xtal_ena;
    logic        xtal_stdby;
    logic        ready;
    logic        fault;
    logic [7:0]  edge_cnt;
    logic [2:0]  state;

    // environment side: drives requests/config/oscillator, observes status
    modport master (
        output en, stdby_req, startup_cycles, min_edges, max_edges, xtal_dout,
        input  xtal_ena, xtal_stdby, ready, fault, edge_cnt, state
    );

    // controller side
    modport slave (
        input  en, stdby_req, startup_cycles, min_edges, max_edges, xtal_dout,
        output xtal_ena, xtal_stdby, ready, fault, edge_cnt, state
    );
endinterface

// File: rtl/sky130_ef_ip__xtal_osc_ctrl.sv
// Crystal oscillator controller.
// Enables the oscillator, waits a programmable startup time, then counts
// crystal rising edges over 256-cycle windows of clk. A window with an edge
// count inside [min_edges, max_edges] declares the crystal good (RUN, ready=1);
// up to three failed windows are allowed at startup before FAULT. In RUN the
// windows continue and a too-low count is treated as clock loss. Standby
// parks the oscillator and re-verifies it on exit. The FSM state is exposed
// on the state output.
module sky130_ef_ip__xtal_osc_ctrl (
    input logic                          clk,
    input logic                          resetn,
    sky130_ef_ip__xtal_osc_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STARTUP = 3'd1,
        ST_MEASURE = 3'd2,
        ST_RUN     = 3'd3,
        ST_STANDBY = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  retry_q, retry_d;

    logic        sync1_q, sync2_q, hist_q;
    logic        rise;

    logic [7:0]  win_cnt_q;
    logic [7:0]  edges_q;
    logic [7:0]  edges_sum;
    logic        counting;
    logic        win_end;
    logic        in_range;

    logic        xtal_ena_q, xtal_stdby_q, ready_q, fault_q;
    logic [7:0]  edge_cnt_q;

    // Bring the asynchronous oscillator output into the clk domain and keep
    // one cycle of history for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= bus.xtal_dout;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise      = sync2_q & ~hist_q;
    assign counting  = (state_q == ST_MEASURE) || (state_q == ST_RUN);
    assign win_end   = counting && (win_cnt_q == 8'hFF);
    // Running count including this cycle's edge, saturating at 255, so an
    // edge on the last window cycle is part of the window result.
    assign edges_sum = (edges_q == 8'hFF) ? 8'hFF : edges_q + {7'd0, rise};
    assign in_range  = (edges_sum >= bus.min_edges) && (edges_sum <= bus.max_edges);

    // Window and edge counters run only while measuring; any other state
    // holds them at zero so every entry into MEASURE starts a fresh window.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_cnt_q  <= 8'd0;
            edges_q    <= 8'd0;
            edge_cnt_q <= 8'd0;
        end else if (counting) begin
            win_cnt_q <= win_cnt_q + 8'd1;
            if (win_end) begin
                edge_cnt_q <= edges_sum;
                edges_q    <= 8'd0;
            end else begin
                edges_q <= edges_sum;
            end
        end else begin
            win_cnt_q <= 8'd0;
            edges_q   <= 8'd0;
        end
    end

    // Next-state, startup timer and retry bookkeeping; en=0 overrides all.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        if (!bus.en) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_STARTUP;
                    timer_d = bus.startup_cycles;
                    retry_d = 2'd0;
                end
                ST_STARTUP: begin
                    if (timer_q == 16'd0) begin
                        state_d = ST_MEASURE;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                ST_MEASURE: begin
                    if (win_end) begin
                        if (in_range) begin
                            state_d = ST_RUN;
                        end else if (retry_q < 2'd2) begin
                            retry_d = retry_q + 2'd1;
                            timer_d = bus.startup_cycles;
                            state_d = ST_STARTUP;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end
                end
                ST_RUN: begin
                    // A clock-loss result on the same cycle as a standby
                    // request is reported rather than hidden by standby.
                    if (win_end && (edges_sum < bus.min_edges)) begin
                        state_d = ST_FAULT;
                    end else if (bus.stdby_req) begin
                        state_d = ST_STANDBY;
                    end
                end
                ST_STANDBY: begin
                    if (!bus.stdby_req) begin
                        state_d = ST_MEASURE;
                        retry_d = 2'd0;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    // State, timer and retry registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_OFF;
            timer_q <= 16'd0;
            retry_q <= 2'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    // Pin drives and status registered from the next state so they change
    // on the same edge as the state itself.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xtal_ena_q   <= 1'b0;
            xtal_stdby_q <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            xtal_ena_q   <= (state_d == ST_STARTUP) || (state_d == ST_MEASURE) ||
                            (state_d == ST_RUN)     || (state_d == ST_STANDBY);
            xtal_stdby_q <= (state_d == ST_STANDBY);
            ready_q      <= (state_d == ST_RUN);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    assign bus.xtal_ena   = xtal_ena_q;
    assign bus.xtal_stdby = xtal_stdby_q;
    assign bus.ready      = ready_q;
    assign bus.fault      = fault_q;
    assign bus.edge_cnt   = edge_cnt_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_sky130_ef_ip__xtal_osc_ctrl.sv
// Bench for the crystal oscillator controller: directed scenarios plus
// randomized segments, every cycle compared against a behavioural model.
module tb_sky130_ef_ip__xtal_osc_ctrl;

    logic clk;
    logic resetn;

    sky130_ef_ip__xtal_osc_ctrl_if bus_if ();

    sky130_ef_ip__xtal_osc_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #12.5 clk = ~clk;   // 40 MHz

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- crystal stimulus ----------------
    // x_num/10 half-periods of the crystal elapse per clk cycle:
    // 8 -> 16 MHz, 10 -> 20 MHz, 0 -> stopped.
    int x_num = 0;
    int x_acc = 0;

    // ---------------- behavioural model ----------------
    // Model states: 0 off, 1 startup, 2 measure, 3 run, 4 standby, 5 fault.
    int m_st, m_wait, m_fails, m_age, m_edges, m_last;
    bit xd[3];   // xd[0] newest sample of xtal_dout taken at a clk edge

    task automatic model_reset();
        m_st = 0; m_wait = 0; m_fails = 0; m_age = 0; m_edges = 0; m_last = 0;
        xd[0] = 0; xd[1] = 0; xd[2] = 0;
    endtask

    task automatic model_step();
        bit measuring, done, edge_now;
        int total, nxt;
        // an input change becomes a counted edge two clk edges after capture
        edge_now  = xd[1] && !xd[2];
        measuring = (m_st == 2) || (m_st == 3);
        total     = measuring ? ((m_edges + edge_now > 255) ? 255 : m_edges + edge_now) : 0;
        done      = measuring && (m_age == 255);
        if (done) m_last = total;
        nxt = m_st;
        if (!bus_if.en) nxt = 0;
        else if (m_st == 0) begin
            nxt = 1; m_wait = bus_if.startup_cycles; m_fails = 0;
        end else if (m_st == 1) begin
            if (m_wait == 0) nxt = 2; else m_wait--;
        end else if (m_st == 2 && done) begin
            if (total >= bus_if.min_edges && total <= bus_if.max_edges) nxt = 3;
            else if (m_fails < 2) begin
                m_fails++; m_wait = bus_if.startup_cycles; nxt = 1;
            end else nxt = 5;
        end else if (m_st == 3) begin
            if (done && total < bus_if.min_edges) nxt = 5;
            else if (bus_if.stdby_req) nxt = 4;
        end else if (m_st == 4) begin
            if (!bus_if.stdby_req) begin nxt = 2; m_fails = 0; end
        end
        m_age   = measuring ? (m_age + 1) % 256 : 0;
        m_edges = (measuring && !done) ? total : 0;
        m_st    = nxt;
        xd[2] = xd[1]; xd[1] = xd[0]; xd[0] = bus_if.xtal_dout;
    endtask

    task automatic compare_all();
        check("state",      32'(bus_if.state),      32'(m_st));
        check("xtal_ena",   32'(bus_if.xtal_ena),   32'(m_st >= 1 && m_st <= 4));
        check("xtal_stdby", 32'(bus_if.xtal_stdby), 32'(m_st == 4));
        check("ready",      32'(bus_if.ready),      32'(m_st == 3));
        check("fault",      32'(bus_if.fault),      32'(m_st == 5));
        check("edge_cnt",   32'(bus_if.edge_cnt),   32'(m_last));
    endtask

    // ---------------- driver tasks ----------------
    // One clk cycle: model advances on the rising edge, outputs compared on
    // the falling edge, then the crystal input advances.
    task automatic tick();
        @(posedge clk);
        if (!resetn) model_reset(); else model_step();
        @(negedge clk);
        compare_all();
        x_acc += x_num;
        bus_if.xtal_dout = ((x_acc / 10) % 2) != 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset_pulse();
        #5;
        resetn = 1'b0;
        #1;
        model_reset();
        check("rst_async_ena",   32'(bus_if.xtal_ena), 32'd0);
        check("rst_async_ready", 32'(bus_if.ready),    32'd0);
        check("rst_async_state", 32'(bus_if.state),    32'd0);
        check("rst_async_ecnt",  32'(bus_if.edge_cnt), 32'd0);
        tick();
        resetn = 1'b1;
    endtask

    task automatic set_cfg(input int sc, input int mn, input int mx);
        bus_if.startup_cycles = 16'(sc);
        bus_if.min_edges      = 8'(mn);
        bus_if.max_edges      = 8'(mx);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        bit found;
        int ec;
        model_reset();
        resetn = 1'b0;
        bus_if.en = 1'b0;
        bus_if.stdby_req = 1'b0;
        bus_if.xtal_dout = 1'b0;
        set_cfg(100, 90, 115);
        ticks(4);
        check("reset_state", 32'(bus_if.state), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        ticks(3);

        // nominal startup, 16 MHz crystal
        x_num = 8;
        bus_if.en = 1'b1;
        tick();
        check("ena_cycle1", 32'(bus_if.xtal_ena), 32'd1);
        k = 1;
        while (bus_if.state != 3'd2 && k < 300) begin tick(); k++; end
        check("measure_cycle", 32'(k), 32'd102);
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin tick(); if (bus_if.ready) found = 1; end
        check("nominal_ready", 32'(found), 32'd1);
        ec = bus_if.edge_cnt;
        check("nominal_edges_in_range", 32'(ec >= 101 && ec <= 103), 32'd1);
        ticks(300);

        // standby and return
        bus_if.stdby_req = 1'b1;
        tick();
        check("stdby_pin", 32'(bus_if.xtal_stdby), 32'd1);
        check("stdby_ready", 32'(bus_if.ready), 32'd0);
        ticks(20);
        bus_if.stdby_req = 1'b0;
        tick();
        check("stdby_exit_measure", 32'(bus_if.state), 32'd2);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin tick(); if (bus_if.ready) found = 1; end
        check("stdby_ready_again", 32'(found), 32'd1);

        // overfrequency while running does not fault
        x_num = 10;
        ticks(800);
        check("overfreq_run_nofault", 32'(bus_if.fault), 32'd0);

        // clock loss
        x_num = 0;
        found = 0;
        for (int i = 0; i < 520 && !found; i++) begin tick(); if (bus_if.fault) found = 1; end
        check("clock_loss_fault", 32'(found), 32'd1);
        check("clock_loss_ready", 32'(bus_if.ready), 32'd0);
        bus_if.en = 1'b0;
        tick();
        check("fault_cleared_off", 32'(bus_if.fault), 32'd0);

        // dead crystal: three windows then fault
        bus_if.en = 1'b1;
        found = 0;
        for (int i = 0; i < 1200 && !found; i++) begin tick(); if (bus_if.fault) found = 1; end
        check("dead_fault", 32'(found), 32'd1);
        check("dead_state", 32'(bus_if.state), 32'd5);
        ticks(10);
        bus_if.en = 1'b0;
        tick();
        check("dead_off", 32'(bus_if.state), 32'd0);

        // overfrequency at startup
        x_num = 10;
        bus_if.en = 1'b1;
        found = 0;
        for (int i = 0; i < 1200 && !found; i++) begin tick(); if (bus_if.fault) found = 1; end
        check("overfreq_start_fault", 32'(found), 32'd1);
        bus_if.en = 1'b0;
        tick();

        // en=0 on a window-end cycle in RUN
        x_num = 8;
        bus_if.en = 1'b1;
        found = 0;
        for (int i = 0; i < 800 && !found; i++) begin tick(); if (bus_if.ready) found = 1; end
        check("prio_reach_run", 32'(found), 32'd1);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (m_st == 3 && m_age == 255) found = 1; else tick();
        end
        check("prio_window_end_found", 32'(found), 32'd1);
        bus_if.en = 1'b0;
        tick();
        check("prio_off", 32'(bus_if.state), 32'd0);
        check("prio_no_ready", 32'(bus_if.ready), 32'd0);

        // asynchronous reset mid-RUN
        bus_if.en = 1'b1;
        ticks(500);
        async_reset_pulse();
        ticks(5);

        // zero startup time: a single STARTUP cycle
        bus_if.en = 1'b0;
        tick();
        set_cfg(0, 90, 115);
        bus_if.en = 1'b1;
        tick();
        check("zero_startup_st", 32'(bus_if.state), 32'd1);
        tick();
        check("zero_startup_meas", 32'(bus_if.state), 32'd2);
        ticks(300);

        // randomized segments
        for (int s = 0; s < 40; s++) begin
            int mn;
            mn = $urandom_range(60, 110);
            set_cfg($urandom_range(0, 40), mn, mn + $urandom_range(0, 40));
            bus_if.en        = ($urandom_range(0, 9) != 0);
            bus_if.stdby_req = ($urandom_range(0, 3) == 0);
            x_num            = $urandom_range(0, 10);
            if ($urandom_range(0, 2) != 0) x_num = 8;
            ticks($urandom_range(50, 600));
            if ($urandom_range(0, 9) == 0) async_reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sky130_ef_ip__xtal_osc_ctrl.md
SKY130_EF_IP__XTAL_OSC_CTRL -- requirements
Module: sky130_ef_ip__xtal_osc_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, clk, and an asynchronous, active-low reset, resetn.
- clk: input, 1 bit, reference clock; rising edge only; frequency at least 2.5x the crystal frequency (40 MHz nominal for 16 MHz).
- resetn: input, 1 bit, asynchronous assert, active low.
REQ-002 The block SHALL provide the following further ports:
- en: input, 1 bit, oscillator enable request (level).
- stdby_req: input, 1 bit, standby request (level).
- startup_cycles: input, 16 bits, startup wait in clk cycles; quasi-static.
- min_edges: input, 8 bits, minimum xtal edges per window; quasi-static.
- max_edges: input, 8 bits, maximum xtal edges per window; quasi-static.
- xtal_dout: input, 1 bit, oscillator digital output; asynchronous to clk.
- xtal_ena: output, 1 bit, drives the oscillator ena pin.
- xtal_stdby: output, 1 bit, drives the oscillator stdby pin.
- ready: output, 1 bit, oscillator verified and running.
- fault: output, 1 bit, startup failure or clock loss.
- edge_cnt: output, 8 bits, edge count from the last completed window.
- state: output, 3 bits, FSM state encoding.

Function
REQ-003 xtal_dout SHALL pass through a 2-flop synchronizer plus one history flop before use.
REQ-004 A rising edge SHALL be counted when the synchronized value is 1 and the history value is 0.
REQ-005 The FSM SHALL use these states and encodings: OFF=0, STARTUP=1, MEASURE=2, RUN=3, STANDBY=4, FAULT=5.
REQ-006 Outputs per state SHALL be:
- OFF: ena=0, stdby=0, ready=0.
- STARTUP: ena=1, stdby=0, ready=0.
- MEASURE: ena=1, stdby=0, ready=0.
- RUN: ena=1, stdby=0, ready=1.
- STANDBY: ena=1, stdby=1, ready=0.
- FAULT: ena=0, stdby=0, fault=1.
- All outputs SHALL be registered.
REQ-007 OFF -> STARTUP when en=1; the 16-bit timer loads startup_cycles and the retry counter clears.
REQ-008 STARTUP SHALL decrement the timer each cycle; at timer==0 -> MEASURE. startup_cycles=0 SHALL give one STARTUP cycle.
REQ-009 A measurement window SHALL be exactly 256 clk cycles, using an 8-bit window counter that wraps 255->0 at window end.
REQ-010 The edge counter SHALL saturate at 255 and clear at the start of each window.
REQ-011 At each window end, edge_cnt SHALL capture the count, including an edge detected on the final cycle.
REQ-012 MEASURE window end, pass (min_edges <= count <= max_edges) -> RUN.
REQ-013 MEASURE window end, fail with retry<2 -> retry+1, timer reloads, -> STARTUP.
REQ-014 MEASURE window end, fail with retry==2 -> FAULT (three failed windows total).
REQ-015 RUN SHALL measure windows continuously; a window end with count < min_edges -> FAULT (clock loss); count > max_edges SHALL be ignored in RUN.
REQ-016 RUN with stdby_req=1 -> STANDBY, and the current window is abandoned.
REQ-017 STANDBY with stdby_req=0 -> MEASURE with a fresh window and retry cleared; ready SHALL stay 0 until a pass.
REQ-018 In FAULT, fault SHALL remain 1 until en=0, then -> OFF, which clears fault.
REQ-019 en=0 in any state SHALL force OFF on the next clk edge, with priority over all other transitions, including a window end in the same cycle.
REQ-020 stdby_req SHALL be ignored in OFF, STARTUP, MEASURE and FAULT.
REQ-021 Transitions SHALL take effect one clk after the condition is sampled; ready SHALL rise on the cycle after the passing window end.

Reset
REQ-022 On resetn=0, the block SHALL force state=OFF and all outputs, counters, timer, retry and synchronizer flops to 0, immediately and asynchronously.
REQ-023 Reset release SHALL be synchronous to clk.
REQ-024 A reset asserted mid-STARTUP or mid-RUN SHALL drop xtal_ena and ready without waiting for clk.

Verification
REQ-025 Nominal startup: clk 40 MHz, xtal 16 MHz, startup_cycles=100, min=90, max=115, en=1 -> xtal_ena=1 at cycle 1, MEASURE at cycle 102, ready=1 about 257 cycles later, edge_cnt in 101..103.
REQ-026 Dead crystal: xtal_dout=0, same configuration -> three STARTUP/MEASURE cycles, then fault=1, xtal_ena=0, state=5; en=0 -> state=0, fault=0.
REQ-027 Clock loss: in RUN, stop xtal_dout -> fault=1 at the end of the first full empty window (at most 512 cycles), ready=0.
REQ-028 Standby: in RUN, stdby_req=1 -> xtal_stdby=1, ready=0 next cycle; stdby_req=0 -> MEASURE, ready=1 after one passing window.
REQ-029 Overfrequency at startup: xtal 20 MHz (about 128 edges), max=115 -> retry then FAULT; the same xtal in RUN SHALL NOT fault.
REQ-030 Priority and reset: en=0 on the window-end cycle -> OFF with no ready pulse; resetn pulse mid-RUN -> all outputs 0 asynchronously.
